descrambler_sync: RTL and testbench

- Receive-side counterpart of the 802.11a scrambler: takes a serial stream of scrambled DATA-field bits from the demapper/decoder path, including the 16-bit SERVICE field.
- Recovers the x^7+x^4+1 LFSR state from the 7 zero init bits of SERVICE, checks the 9 reserved SERVICE bits, then descrambles and emits the PSDU bits.
- Sits between the Viterbi decoder output and the MAC-side byte packer.

---
 rtl/descrambler_sync_if.sv | 35 +++
 rtl/descrambler_sync.sv | 158 +++++++++++++++
 tb/tb_descrambler_sync.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/descrambler_sync_if.sv
// descrambler_sync_if
//   Bus bundle between the bit source (Viterbi side), the descrambler and
//   its status consumers.
//   master : drives start/frame_bits/in_bit/in_valid, observes results
//   slave  : the descrambler itself
//   Signals: start, frame_bits[LEN_W], in_bit, in_valid -> descrambler
//            out_bit, out_valid, out_last, lfsr_state[7], state_valid,
//            service_err, frame_done, busy, seed_zero_err <- descrambler
interface descrambler_sync_if #(parameter int LEN_W = 16);
  logic             start;
  logic [LEN_W-1:0] frame_bits;
  logic             in_bit;
  logic             in_valid;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic [6:0]       lfsr_state;
  logic             state_valid;
  logic             service_err;
  logic             frame_done;
  logic             busy;
  logic             seed_zero_err;

  modport master (
    output start, frame_bits, in_bit, in_valid,
    input  out_bit, out_valid, out_last, lfsr_state, state_valid,
           service_err, frame_done, busy, seed_zero_err
  );

  modport slave (
    input  start, frame_bits, in_bit, in_valid,
    output out_bit, out_valid, out_last, lfsr_state, state_valid,
           service_err, frame_done, busy, seed_zero_err
  );
endinterface

// File: rtl/descrambler_sync.sv
// descrambler_sync
//   802.11a receive descrambler (x^7+x^4+1). Recovers the scrambler state
//   from the 7 zero sync bits of SERVICE, checks the reserved SERVICE bits,
//   then descrambles and emits the PSDU bits serially.
//   Ports: clk, reset (async, active high), bus (descrambler_sync_if.slave)
//   Optional: DESCRAMBLER_SEED_ZERO_CHECK_EN -- abort the frame with
//   seed_zero_err/frame_done when the recovered state is all zero.
module descrambler_sync #(
  parameter int LEN_W        = 16,
  parameter int SERVICE_BITS = 16
) (
  input logic               clk,
  input logic               reset,
  descrambler_sync_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SYNC, SERVICE, DATA} state_t;

  localparam logic [LEN_W-1:0] SB        = LEN_W'(SERVICE_BITS);
  localparam logic [LEN_W-1:0] SYNC_LAST = LEN_W'(6);

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt, r_target, w_target_nxt;
  logic [6:0]       r_lfsr, w_lfsr_nxt;
  logic             r_out_bit, w_out_bit_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_out_last, w_out_last_nxt;
  logic             r_state_valid, w_state_valid_nxt;
  logic             r_service_err, w_service_err_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             w_p, w_desc;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [6:0]       w_sync_lfsr;
`ifdef DESCRAMBLER_SEED_ZERO_CHECK_EN
  logic             r_seed_zero_err, w_seed_zero_err_nxt;
`endif

  // r_lfsr[6] is s7 (oldest), r_lfsr[3] is s4.
  assign w_p         = r_lfsr[6] ^ r_lfsr[3];
  assign w_desc      = bus.in_bit ^ w_p;
  assign w_cnt_inc   = r_cnt + LEN_W'(1);
  assign w_sync_lfsr = {r_lfsr[5:0], bus.in_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_target_nxt      = r_target;
    w_lfsr_nxt        = r_lfsr;
    w_out_bit_nxt     = r_out_bit;
    w_out_valid_nxt   = 1'b0;
    w_out_last_nxt    = 1'b0;
    w_state_valid_nxt = r_state_valid;
    w_service_err_nxt = r_service_err;
    w_frame_done_nxt  = 1'b0;
`ifdef DESCRAMBLER_SEED_ZERO_CHECK_EN
    w_seed_zero_err_nxt = 1'b0;
`endif
    if (bus.start) begin
      // start wins over everything, including an in_valid in the same cycle
      w_state_nxt       = SYNC;
      w_cnt_nxt         = '0;
      w_target_nxt      = (bus.frame_bits < SB) ? SB : bus.frame_bits;
      w_state_valid_nxt = 1'b0;
      w_service_err_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        SYNC: begin
          // sync bits are zero on air, so scrambled bit == sequence bit
          if (bus.in_valid) begin
            w_lfsr_nxt = w_sync_lfsr;
            w_cnt_nxt  = w_cnt_inc;
            if (r_cnt == SYNC_LAST) begin
              w_state_valid_nxt = 1'b1;
              w_state_nxt       = SERVICE;
`ifdef DESCRAMBLER_SEED_ZERO_CHECK_EN
              if (w_sync_lfsr == 7'b0) begin
                w_state_valid_nxt   = 1'b0;
                w_state_nxt         = IDLE;
                w_seed_zero_err_nxt = 1'b1;
                w_frame_done_nxt    = 1'b1;
              end
`endif
            end
          end
        end
        SERVICE, DATA: begin
          // the cycle after the last bit closes the frame; in_valid ignored
          if (r_cnt == r_target) begin
            w_frame_done_nxt  = 1'b1;
            w_state_valid_nxt = 1'b0;
            w_state_nxt       = IDLE;
          end else if (bus.in_valid) begin
            w_lfsr_nxt = {r_lfsr[5:0], w_p};
            w_cnt_nxt  = w_cnt_inc;
            if (r_state == SERVICE) begin
              if (w_desc) w_service_err_nxt = 1'b1;
              // r_target is never below SB, so != means more bits follow
              if (w_cnt_inc == SB && r_target != SB) w_state_nxt = DATA;
            end else begin
              w_out_bit_nxt   = w_desc;
              w_out_valid_nxt = 1'b1;
              w_out_last_nxt  = (w_cnt_inc == r_target);
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_target      <= '0;
      r_lfsr        <= '0;
      r_out_bit     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_state_valid <= 1'b0;
      r_service_err <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_target      <= w_target_nxt;
      r_lfsr        <= w_lfsr_nxt;
      r_out_bit     <= w_out_bit_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_last    <= w_out_last_nxt;
      r_state_valid <= w_state_valid_nxt;
      r_service_err <= w_service_err_nxt;
      r_frame_done  <= w_frame_done_nxt;
    end
  end

`ifdef DESCRAMBLER_SEED_ZERO_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_seed_zero_err <= 1'b0;
    else       r_seed_zero_err <= w_seed_zero_err_nxt;
  end
  assign bus.seed_zero_err = r_seed_zero_err;
`else
  assign bus.seed_zero_err = 1'b0;
`endif

  assign bus.out_bit     = r_out_bit;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_last    = r_out_last;
  assign bus.lfsr_state  = r_lfsr;
  assign bus.state_valid = r_state_valid;
  assign bus.service_err = r_service_err;
  assign bus.frame_done  = r_frame_done;
  assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_descrambler_sync.sv
// tb_descrambler_sync
//   Directed frames: clean, gapped, SERVICE error, short frame, abort,
//   reset mid-frame, all-zero seed. Stream bits are listed in air order.
module tb_descrambler_sync;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_ov = 0, n_last = 0, n_done = 0;

  descrambler_sync_if #(.LEN_W(16)) intf();

  descrambler_sync #(.LEN_W(16), .SERVICE_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (intf.out_valid)  n_ov++;
    if (intf.out_last)   n_last++;
    if (intf.frame_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // transmit-side scrambler used to build stimulus for other seeds
  function automatic logic [0:63] scramble(input logic [6:0] seed, input logic [0:63] plain, input int n);
    logic [6:0] s;
    logic       p;
    logic [0:63] o;
    s = seed;
    o = '0;
    for (int i = 0; i < n; i++) begin
      p    = s[6] ^ s[3];
      o[i] = plain[i] ^ p;
      s    = {s[5:0], p};
    end
    return o;
  endfunction

  task automatic run_frame(input logic [0:63] s, input int nb, input int fb,
                           input logic [0:7] d, input bit gaps, input bit junk,
                           output logic [6:0] l7, output logic sv7, output logic e10);
    l7 = '0; sv7 = 1'b0; e10 = 1'b0;
    intf.frame_bits = fb[15:0];
    intf.start      = 1'b1;
    intf.in_valid   = junk;
    intf.in_bit     = 1'b1;
    step();
    intf.start    = 1'b0;
    intf.in_valid = 1'b0;
    chk("busy_on", intf.busy, 1);
    chk("serr_clr", intf.service_err, 0);
    for (int i = 0; i < nb; i++) begin
      intf.in_bit   = s[i];
      intf.in_valid = 1'b1;
      step();
      intf.in_valid = 1'b0;
      if (i == 5) chk("sv_early", intf.state_valid, 0);
      if (i == 6) begin l7 = intf.lfsr_state; sv7 = intf.state_valid; end
      if (i == 9) e10 = intf.service_err;
      if (i >= 16) begin
        chk("dval", intf.out_valid, 1);
        chk("dbit", intf.out_bit, d[i-16]);
        chk("dlast", intf.out_last, (i == nb-1));
      end else begin
        chk("nodata", intf.out_valid, 0);
      end
      if (gaps) begin
        step();
        chk("gap", intf.out_valid, 0);
      end
    end
    if (!gaps) step();
    chk("done", intf.frame_done, 1);
    chk("idle", intf.busy, 0);
    chk("sv_clr", intf.state_valid, 0);
    step();
    chk("done_pulse", intf.frame_done, 0);
  endtask

  logic [0:63] st1, st2, st3, pl;
  logic [0:7]  dat;
  logic [6:0]  l7;
  logic        sv7, e10;
  int          ov0, last0, done0;

  initial begin
    reset = 1'b1;
    intf.start = 1'b0; intf.frame_bits = '0; intf.in_bit = 1'b0; intf.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", intf.busy, 0);
    chk("rst_lfsr", intf.lfsr_state, 0);
    chk("rst_outs", {intf.out_bit, intf.out_valid, intf.out_last, intf.state_valid,
                     intf.service_err, intf.frame_done, intf.seed_zero_err}, 0);
    reset = 1'b0;
    // in_valid in IDLE is ignored
    intf.in_valid = 1'b1; intf.in_bit = 1'b1;
    step();
    intf.in_valid = 1'b0;
    chk("idle_ign", intf.busy, 0);

    // seed 1111111: sequence 0000111 0 11110010 11001001, data 10110001
    dat = 8'b10110001;
    st1 = '0;
    st1[0:23] = 24'b0000111_0_11110010_01111000;

    // clean frame
    run_frame(st1, 24, 24, dat, 1'b0, 1'b0, l7, sv7, e10);
    chk("lfsr7", l7, 7'b0000111);
    chk("sv7", sv7, 1);
    chk("serr_clean", intf.service_err, 0);

    // gapped frame
    ov0 = n_ov; last0 = n_last;
    run_frame(st1, 24, 24, dat, 1'b1, 1'b0, l7, sv7, e10);
    chk("lfsr7_gap", l7, 7'b0000111);
    chk("ov_gap", n_ov - ov0, 8);
    chk("last_gap", n_last - last0, 1);

    // SERVICE bit 9 flipped: error by bit 10, sticky, data unaffected
    st2 = st1;
    st2[9] = ~st2[9];
    run_frame(st2, 24, 24, dat, 1'b0, 1'b0, l7, sv7, e10);
    chk("serr_b10", e10, 1);
    chk("serr_hold", intf.service_err, 1);

    // short frame: full SERVICE consumed, no data
    ov0 = n_ov; done0 = n_done;
    run_frame(st1, 16, 10, dat, 1'b0, 1'b0, l7, sv7, e10);
    chk("short_ov", n_ov - ov0, 0);
    chk("short_done", n_done - done0, 1);
    chk("short_serr", intf.service_err, 0);

    // abort at data bit 3, restart with seed 1011101 (first bits 0110110)
    last0 = n_last; done0 = n_done; ov0 = n_ov;
    intf.frame_bits = 16'd24; intf.start = 1'b1;
    step();
    intf.start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      intf.in_bit = st1[i]; intf.in_valid = 1'b1;
      step();
      intf.in_valid = 1'b0;
    end
    pl = '0;
    pl[16:23] = dat;
    st3 = scramble(7'b1011101, pl, 24);
    run_frame(st3, 24, 24, dat, 1'b0, 1'b1, l7, sv7, e10);
    chk("ab_lfsr7", l7, 7'b0110110);
    chk("ab_last", n_last - last0, 1);
    chk("ab_done", n_done - done0, 1);
    chk("ab_ov", n_ov - ov0, 3 + 8);

    // reset mid-frame
    done0 = n_done;
    intf.frame_bits = 16'd24; intf.start = 1'b1;
    step();
    intf.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      intf.in_bit = st1[i]; intf.in_valid = 1'b1;
      step();
    end
    intf.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst_busy", intf.busy, 0);
    chk("mrst_outs", {intf.out_valid, intf.state_valid, intf.lfsr_state}, 0);
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("mrst_nodone", n_done - done0, 0);

    // all-zero seed
    st3 = '0;
    ov0 = n_ov; done0 = n_done;
`ifdef DESCRAMBLER_SEED_ZERO_CHECK_EN
    intf.frame_bits = 16'd24; intf.start = 1'b1;
    step();
    intf.start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      intf.in_bit = 1'b0; intf.in_valid = 1'b1;
      step();
      if (i == 6) begin
        chk("sz_err", intf.seed_zero_err, 1);
        chk("sz_done", intf.frame_done, 1);
      end
      if (i == 7) begin
        chk("sz_pulse", intf.seed_zero_err, 0);
        chk("sz_busy", intf.busy, 0);
      end
    end
    intf.in_valid = 1'b0;
    repeat (2) step();
    chk("sz_ov", n_ov - ov0, 0);
    chk("sz_ndone", n_done - done0, 1);
`else
    run_frame(st3, 16, 16, dat, 1'b0, 1'b0, l7, sv7, e10);
    chk("z_lfsr", l7, 0);
    chk("z_sv", sv7, 1);
    chk("z_serr", intf.service_err, 0);
    chk("z_szerr", intf.seed_zero_err, 0);
    chk("z_ov", n_ov - ov0, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
